// File: rtl/formula_sqrt_sum_pipe_aware_fsm_pkg.sv
// formula_sqrt_sum_pkg: FSM states and counter-width helper for the sqrt-sum block
package formula_sqrt_sum_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT} state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/formula_sqrt_sum_pipe_aware_fsm_if.sv
// formula_sqrt_sum_pipe_aware_fsm_if: argument/result handshake plus shared isqrt request/response
interface formula_sqrt_sum_pipe_aware_fsm_if #(
  parameter int N_ARGS = 3,
  parameter int X_W = 32,
  parameter int Y_W = X_W / 2,
  parameter int RES_W = 32
);
  logic arg_vld;
  logic arg_rdy;
  logic [N_ARGS*X_W-1:0] args;
  logic res_vld;
  logic [RES_W-1:0] res;
  logic isqrt_x_vld;
  logic [X_W-1:0] isqrt_x;
  logic isqrt_y_vld;
  logic [Y_W-1:0] isqrt_y;
  modport master (
    output arg_vld, args, isqrt_y_vld, isqrt_y,
    input arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
  modport slave (
    input arg_vld, args, isqrt_y_vld, isqrt_y,
    output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
  );
endinterface

// File: rtl/formula_sqrt_sum_pipe_aware_fsm_acc.sv
// formula_sqrt_sum_acc: clearable accumulator, wraps or saturates (FORMULA_SQRT_SUM_SAT_EN)
module formula_sqrt_sum_acc #(
  parameter int RES_W = 32,
  parameter int IN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic [IN_W-1:0]  din,
  output logic [RES_W-1:0] acc
);
  localparam int SW = (RES_W > IN_W ? RES_W : IN_W) + 1;
  logic [SW-1:0] sum;
  logic [RES_W-1:0] nxt;
  always_comb begin
    sum = SW'(acc) + SW'(din);
`ifdef FORMULA_SQRT_SUM_SAT_EN
    nxt = |sum[SW-1:RES_W] ? '1 : sum[RES_W-1:0];
`else
    nxt = sum[RES_W-1:0];
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= clr ? '0 : add ? nxt : acc;
endmodule

// File: rtl/formula_sqrt_sum_pipe_aware_fsm.sv
// formula_sqrt_sum_pipe_aware_fsm: issues N_ARGS args back-to-back to a shared isqrt and sums the roots (FORMULA_SQRT_SUM_SAT_EN)
module formula_sqrt_sum_pipe_aware_fsm
  import formula_sqrt_sum_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int X_W = 32,
  parameter int Y_W = X_W / 2,
  parameter int RES_W = 32
) (
  input logic clk,
  input logic rst,
  formula_sqrt_sum_pipe_aware_fsm_if.slave bus
);
  localparam int CW = cnt_w(N_ARGS);
  state_e state, state_n;
  logic [CW-1:0] iss_cnt, rcv_cnt;
  logic [N_ARGS*X_W-1:0] args_q;
  logic take, rcv, last;
  always_comb begin
    take = state == IDLE && bus.arg_vld;
    rcv = state != IDLE && bus.isqrt_y_vld;
    last = rcv && rcv_cnt == CW'(N_ARGS - 1);
    bus.arg_rdy = state == IDLE;
    bus.isqrt_x_vld = take || state == ISSUE;
    bus.isqrt_x = state == IDLE ? bus.args[X_W-1:0] : args_q[int'(iss_cnt)*X_W +: X_W];
    state_n = last ? IDLE
            : take ? (N_ARGS > 1 ? ISSUE : COLLECT)
            : state == ISSUE && iss_cnt == CW'(N_ARGS - 1) ? COLLECT
            : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      iss_cnt <= '0;
      rcv_cnt <= '0;
      args_q <= '0;
      bus.res_vld <= 1'b0;
    end else begin
      state <= state_n;
      bus.res_vld <= last;
      if (take) begin
        args_q <= bus.args;
        iss_cnt <= CW'(1);
        rcv_cnt <= '0;
      end else begin
        if (state == ISSUE) iss_cnt <= iss_cnt + 1'b1;
        if (rcv) rcv_cnt <= rcv_cnt + 1'b1;
      end
    end
  formula_sqrt_sum_acc #(.RES_W(RES_W), .IN_W(Y_W)) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(take),
    .add(rcv),
    .din(bus.isqrt_y),
    .acc(bus.res)
  );
endmodule

// File: tb/tb_formula_sqrt_sum_pipe_aware_fsm.sv
// tb_formula_sqrt_sum_pipe_aware_fsm: directed checks against a latency-4 behavioural isqrt
module tb_formula_sqrt_sum_pipe_aware_fsm;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  formula_sqrt_sum_pipe_aware_fsm_if #(.N_ARGS(3), .RES_W(32)) ia ();
  formula_sqrt_sum_pipe_aware_fsm_if #(.N_ARGS(3), .RES_W(4)) ib ();
  formula_sqrt_sum_pipe_aware_fsm_if #(.N_ARGS(1), .RES_W(32)) ic ();
  formula_sqrt_sum_pipe_aware_fsm #(.N_ARGS(3), .RES_W(32)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  formula_sqrt_sum_pipe_aware_fsm #(.N_ARGS(3), .RES_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  formula_sqrt_sum_pipe_aware_fsm #(.N_ARGS(1), .RES_W(32)) dut_c (.clk(clk), .rst(rst), .bus(ic));
  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (32'(t) * 32'(t) <= x) r = t;
    end
    return r;
  endfunction
  logic [2:0] xv;
  logic [31:0] xx [3];
  logic [3:0] pv [3];
  logic [15:0] py [3][4];
  assign xv = {ic.isqrt_x_vld, ib.isqrt_x_vld, ia.isqrt_x_vld};
  assign xx[0] = ia.isqrt_x;
  assign xx[1] = ib.isqrt_x;
  assign xx[2] = ic.isqrt_x;
  assign ia.isqrt_y_vld = pv[0][3];
  assign ib.isqrt_y_vld = pv[1][3];
  assign ic.isqrt_y_vld = pv[2][3];
  assign ia.isqrt_y = py[0][3];
  assign ib.isqrt_y = py[1][3];
  assign ic.isqrt_y = py[2][3];
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 3; k++) pv[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        pv[k] <= {pv[k][2:0], xv[k]};
        py[k][0] <= isqrt(xx[k]);
        for (int s = 1; s < 4; s++) py[k][s] <= py[k][s-1];
      end
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  localparam logic [95:0] SET1 = {32'd25, 32'd9, 32'd16};
  localparam logic [95:0] SET2 = {32'd100, 32'd4, 32'd1};
  localparam logic [3:0] SAT_EXP =
`ifdef FORMULA_SQRT_SUM_SAT_EN
    4'd15;
`else
    4'd13;
`endif
  initial begin
    logic [31:0] cx [3];
    logic [31:0] ce [3];
    cx = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    ce = '{32'd0, 32'd1, 32'd65535};
    rst = 1'b1;
    ia.arg_vld = 1'b0; ia.args = '0;
    ib.arg_vld = 1'b0; ib.args = '0;
    ic.arg_vld = 1'b0; ic.args = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res_vld", ia.res_vld, 0);
    chk("rst_res", ia.res, 0);
    chk("rst_xvld", ia.isqrt_x_vld, 0);
    chk("rst_rdy", ia.arg_rdy, 1);
    chk("rst_b_rdy", ib.arg_rdy, 1);
    chk("rst_c_res", ic.res, 0);
    @(negedge clk) rst = 1'b0;
    // basic set with ignored pulses during the busy cycles
    @(negedge clk) begin ia.arg_vld = 1'b1; ia.args = SET1; end
    #1;
    chk("t1_c0_rdy", ia.arg_rdy, 1);
    chk("t1_c0_xvld", ia.isqrt_x_vld, 1);
    chk("t1_c0_x", ia.isqrt_x, 16);
    @(negedge clk) ia.arg_vld = 1'b0;
    #1;
    chk("t1_c1_rdy", ia.arg_rdy, 0);
    chk("t1_c1_x", ia.isqrt_x, 9);
    @(negedge clk) begin ia.arg_vld = 1'b1; ia.args = SET2; end
    #1;
    chk("t1_c2_rdy", ia.arg_rdy, 0);
    chk("t1_c2_xvld", ia.isqrt_x_vld, 1);
    chk("t1_c2_x", ia.isqrt_x, 25);
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      #1;
      chk("t1_busy_rdy", ia.arg_rdy, 0);
      chk("t1_busy_xvld", ia.isqrt_x_vld, 0);
      chk("t1_busy_res_vld", ia.res_vld, 0);
    end
    @(negedge clk) ia.arg_vld = 1'b0;
    #1;
    chk("t1_c6_res_vld", ia.res_vld, 0);
    @(negedge clk);
    #1;
    chk("t1_c7_res_vld", ia.res_vld, 1);
    chk("t1_c7_res", ia.res, 12);
    chk("t1_c7_rdy", ia.arg_rdy, 1);
    @(negedge clk);
    #1;
    chk("t1_c8_res_vld", ia.res_vld, 0);
    chk("t1_c8_res_hold", ia.res, 12);
    // back-to-back with arg_vld held high
    @(negedge clk) begin ia.arg_vld = 1'b1; ia.args = SET1; end
    #1;
    chk("t2_c0_x", ia.isqrt_x, 16);
    @(negedge clk) ia.args = SET2;
    repeat (5) @(negedge clk);
    #1;
    chk("t2_c6_res_vld", ia.res_vld, 0);
    @(negedge clk);
    #1;
    chk("t2_c7_res_vld", ia.res_vld, 1);
    chk("t2_c7_res", ia.res, 12);
    chk("t2_c7_rdy", ia.arg_rdy, 1);
    chk("t2_c7_x", ia.isqrt_x, 1);
    @(negedge clk);
    #1;
    chk("t2_c8_res_clr", ia.res, 0);
    chk("t2_c8_res_vld", ia.res_vld, 0);
    chk("t2_c8_x", ia.isqrt_x, 4);
    repeat (6) @(negedge clk);
    ia.arg_vld = 1'b0;
    #1;
    chk("t2_c14_res_vld", ia.res_vld, 1);
    chk("t2_c14_res", ia.res, 13);
    chk("t2_c14_rdy", ia.arg_rdy, 1);
    // reset in the middle of an operation
    @(negedge clk) begin ia.arg_vld = 1'b1; ia.args = SET1; end
    @(negedge clk) ia.arg_vld = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t3_c5_partial", ia.res, 4);
    rst = 1'b1;
    #1;
    chk("t3_rst_res_vld", ia.res_vld, 0);
    chk("t3_rst_res", ia.res, 0);
    chk("t3_rst_rdy", ia.arg_rdy, 1);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) begin ia.arg_vld = 1'b1; ia.args = SET1; end
    #1;
    chk("t3_c0_x", ia.isqrt_x, 16);
    @(negedge clk) ia.arg_vld = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t3_c6_res_vld", ia.res_vld, 0);
    @(negedge clk);
    #1;
    chk("t3_c7_res_vld", ia.res_vld, 1);
    chk("t3_c7_res", ia.res, 12);
    // narrow accumulator overflow
    @(negedge clk) begin ib.arg_vld = 1'b1; ib.args = '1; end
    @(negedge clk) ib.arg_vld = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t4_c6_res_vld", ib.res_vld, 0);
    @(negedge clk);
    #1;
    chk("t4_c7_res_vld", ib.res_vld, 1);
    chk("t4_c7_res", ib.res, SAT_EXP);
    // single-argument instance
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) begin ic.arg_vld = 1'b1; ic.args = cx[i]; end
      #1;
      chk("t5_c0_xvld", ic.isqrt_x_vld, 1);
      chk("t5_c0_x", ic.isqrt_x, cx[i]);
      @(negedge clk) ic.arg_vld = 1'b0;
      #1;
      chk("t5_c1_rdy", ic.arg_rdy, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("t5_c4_res_vld", ic.res_vld, 0);
      @(negedge clk);
      #1;
      chk("t5_c5_res_vld", ic.res_vld, 1);
      chk("t5_c5_res", ic.res, ce[i]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
